add_arb: RTL and testbench
==========================

ADD_ARB -- requirements
Module: add_arb

Interface
REQ-001 The block SHALL have parameter LAT, default 1, meaning the number of EXEC cycles the 8-bit ripple adder settles before result capture; legal range 1..4, other values rejected at elaboration.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 The block SHALL have ports req0 / req1  input  1  operation request from requester 0 / 1.
REQ-005 The block SHALL have ports a0, b0 / a1, b1  input  8 each  operands of requester 0 / 1.
REQ-006 The block SHALL have ports gnt0 / gnt1  output  1  single-cycle grant to requester 0 / 1.
REQ-007 The block SHALL have port rsp_rdy  input  1  result consumer ready.
REQ-008 The block SHALL have port rsp_vld  output  1  result valid.
REQ-009 The block SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-010 The block SHALL have port sum  output  8  registered result, (a+b) mod 256.
REQ-011 The block SHALL have port car  output  1  registered carry out of bit 7.
REQ-012 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL instantiate exactly one 8-bit ripple-carry adder (carry-in 0), driven only from internal operand registers op_a/op_b.
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP; encoding is free.
REQ-015 In IDLE with req0 or req1 high at a rising edge, the FSM SHALL latch the winner's operands into op_a/op_b, record its id, clear the cycle counter and enter EXEC.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; the last-served pointer SHALL reset to 1, so requester 0 wins first.
REQ-017 With a single request high, that requester SHALL win regardless of the pointer.
REQ-018 gntN SHALL be high for exactly the first EXEC cycle of requester N's operation, and low at all other times.
REQ-019 gnt0 and gnt1 SHALL never be high together.
REQ-020 Requesters SHALL hold reqN and operands stable until gntN is seen; requests arriving outside IDLE SHALL be ignored until the next IDLE sample.
REQ-021 EXEC SHALL last exactly LAT cycles; on the last EXEC edge, the adder outputs SHALL be captured into sum/car, rsp_id set, and the FSM enter RESP.
REQ-022 rsp_vld SHALL rise LAT clock edges after the edge that sampled the request.
REQ-023 In RESP, rsp_vld SHALL be 1; sum, car and rsp_id SHALL be held stable until a rising edge with rsp_rdy=1.
REQ-024 That rsp_rdy edge SHALL return the FSM to IDLE, clear rsp_vld and set the last-served pointer to rsp_id.
REQ-025 sum/car SHALL retain their last value after the handshake; only rsp_vld qualifies them.
REQ-026 Minimum issue interval SHALL be LAT+2 cycles per operation; the FSM has no direct RESP-to-EXEC path.
REQ-027 Arithmetic SHALL be unsigned: {car,sum} = a + b, 9-bit result, no saturation.

Reset
REQ-028 While rst_n=0, the outputs SHALL be gnt0=gnt1=0, rsp_vld=0, rsp_id=0, sum=8'h00, car=0 and busy=0, and the FSM SHALL be in IDLE with the counter 0, op_a/op_b 0 and the pointer 1.
REQ-029 Reset asserted mid-operation (EXEC or RESP) SHALL abort it immediately, with no response produced after release.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to sample requests.

Verification
REQ-031 Reset with all inputs X then 0 -> all outputs 0 during reset and on the first cycle after release.
REQ-032 LAT=1, req0 with a0=8'h0F, b0=8'h01, rsp_rdy=1 -> gnt0 for one cycle; next cycle rsp_vld=1, sum=8'h10, car=0, rsp_id=0; busy for 2 cycles.
REQ-033 Operands a1=8'hFF, b1=8'h01 -> sum=8'h00, car=1, rsp_id=1; operands 8'h80+8'h80 -> sum=8'h00, car=1.
REQ-034 req0 and req1 both held high continuously after reset, rsp_rdy=1 -> grants in the order 0,1,0,1, no overlap, grants spaced LAT+2 cycles apart.
REQ-035 LAT=3, rsp_rdy held low 5 cycles in RESP -> rsp_vld, sum, car and rsp_id stable; no grant issued despite pending req1; rsp_rdy=1 -> IDLE next edge, then req1 granted.
REQ-036 rst_n pulsed low during EXEC of a pending op -> outputs cleared immediately; no rsp_vld after release until a new request is served.

Source files
------------

// File: rtl/add_arb.sv
// add_arb: two-requester round-robin arbiter in front of a single 8-bit ripple-carry adder
module add_arb #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       rsp_rdy,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rsp_vld,
    output logic       rsp_id,
    output logic [7:0] sum,
    output logic       car,
    output logic       busy
);
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("add_arb: LAT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic       r_id;
    logic       r_ptr;
    logic       w_pick;
    logic [8:0] w_c;
    logic [7:0] w_s;

    // Ripple-carry chain fed only from the operand registers
    assign w_c[0] = 1'b0;
    for (genvar i = 0; i < 8; i++) begin : g_rca
        assign w_s[i]   = r_op_a[i] ^ r_op_b[i] ^ w_c[i];
        assign w_c[i+1] = (r_op_a[i] & r_op_b[i]) | (w_c[i] & (r_op_a[i] ^ r_op_b[i]));
    end

    // Contention goes to the requester not served last; a lone request always wins
    assign w_pick = (req0 && req1) ? ~r_ptr : req1;
    assign busy   = (r_state != IDLE);

    // Arbitration FSM with registered grant and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_op_a  <= 8'h00;
            r_op_b  <= 8'h00;
            r_id    <= 1'b0;
            r_ptr   <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_id  <= 1'b0;
            sum     <= 8'h00;
            car     <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (r_state)
                IDLE: if (req0 || req1) begin
                    r_op_a  <= w_pick ? a1 : a0;
                    r_op_b  <= w_pick ? b1 : b0;
                    r_id    <= w_pick;
                    r_cnt   <= 2'd0;
                    gnt0    <= ~w_pick;
                    gnt1    <= w_pick;
                    r_state <= EXEC;
                end
                EXEC: if (r_cnt == 2'(LAT - 1)) begin
                    sum     <= w_s;
                    car     <= w_c[8];
                    rsp_id  <= r_id;
                    rsp_vld <= 1'b1;
                    r_state <= RESP;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
                RESP: if (rsp_rdy) begin
                    rsp_vld <= 1'b0;
                    r_ptr   <= rsp_id;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: directed vector bench for add_arb at LAT=1 and LAT=3
module tb_add_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, rsp_rdy;
    logic [7:0] a0, b0, a1, b1;
    logic       d1_gnt0, d1_gnt1, d1_vld, d1_id, d1_car, d1_busy;
    logic [7:0] d1_sum;
    logic       d3_gnt0, d3_gnt1, d3_vld, d3_id, d3_car, d3_busy;
    logic [7:0] d3_sum;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    add_arb #(.LAT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .rsp_rdy(rsp_rdy),
        .gnt0(d1_gnt0), .gnt1(d1_gnt1), .rsp_vld(d1_vld), .rsp_id(d1_id),
        .sum(d1_sum), .car(d1_car), .busy(d1_busy)
    );

    add_arb #(.LAT(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .rsp_rdy(rsp_rdy),
        .gnt0(d3_gnt0), .gnt1(d3_gnt1), .rsp_vld(d3_vld), .rsp_id(d3_id),
        .sum(d3_sum), .car(d3_car), .busy(d3_busy)
    );

    typedef struct {
        logic       r0, r1;
        logic [7:0] x0, y0, x1, y1;
        logic       id;
        logic [7:0] s;
        logic       c;
    } vec_t;

    task automatic chk(input string n, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zeros1(input string n);
        chk({n, " d1 outs"}, {2'b0, d1_gnt0, d1_gnt1, d1_vld, d1_id, d1_car, d1_busy, |d1_sum}, 9'h0);
    endtask

    task automatic zeros3(input string n);
        chk({n, " d3 outs"}, {2'b0, d3_gnt0, d3_gnt1, d3_vld, d3_id, d3_car, d3_busy, |d3_sum}, 9'h0);
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_rdy = 1;
        rst_n = 0;
        #13;
        rst_n = 1;
        #1;
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{1, 0, 8'h0F, 8'h01, 8'h00, 8'h00, 0, 8'h10, 0};
        vt[1] = '{0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 1, 8'h00, 1};
        vt[2] = '{1, 0, 8'h80, 8'h80, 8'h00, 8'h00, 0, 8'h00, 1};
        vt[3] = '{1, 1, 8'h01, 8'h02, 8'h12, 8'h34, 1, 8'h46, 0};
        vt[4] = '{1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 8'hFE, 1};
        vt[5] = '{0, 1, 8'h00, 8'h00, 8'h7F, 8'h01, 1, 8'h80, 0};
        vt[6] = '{0, 1, 8'h00, 8'h00, 8'hC8, 8'h64, 1, 8'h2C, 1};

        // Reset with X inputs, then zero inputs and release
        req0 = 'x; req1 = 'x; a0 = 'x; b0 = 'x; a1 = 'x; b1 = 'x; rsp_rdy = 'x;
        rst_n = 0;
        #3;
        zeros1("reset X");
        zeros3("reset X");
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_rdy = 1;
        #10;
        rst_n = 1;
        tick();
        zeros1("post reset");
        zeros3("post reset");

        // LAT=1 single-operation vectors, round-robin pointer carried across them
        foreach (vt[k]) begin
            req0 = vt[k].r0; req1 = vt[k].r1;
            a0 = vt[k].x0; b0 = vt[k].y0; a1 = vt[k].x1; b1 = vt[k].y1;
            tick();
            chk($sformatf("v%0d gnt", k), {7'b0, d1_gnt1, d1_gnt0}, vt[k].id ? 9'd2 : 9'd1);
            chk($sformatf("v%0d exec", k), {7'b0, d1_busy, d1_vld}, 9'd2);
            req0 = 0; req1 = 0;
            tick();
            chk($sformatf("v%0d rsp", k), {d1_vld, d1_id, d1_car, d1_gnt0, d1_gnt1, 4'b0},
                {1'b1, vt[k].id, vt[k].c, 6'b0});
            chk($sformatf("v%0d sum", k), {1'b0, d1_sum}, {1'b0, vt[k].s});
            chk($sformatf("v%0d busy rsp", k), {8'b0, d1_busy}, 9'd1);
            tick();
            chk($sformatf("v%0d idle", k), {7'b0, d1_vld, d1_busy}, 9'd0);
            chk($sformatf("v%0d retain", k), {d1_car, d1_sum}, {vt[k].c, vt[k].s});
        end

        // Both requests held continuously: grants 0,1,0,1 every LAT+2 cycles
        req0 = 0; req1 = 0; rsp_rdy = 1;
        rst_n = 0;
        #3;
        req0 = 1; req1 = 1; a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
        #10;
        rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk($sformatf("rr c%0d", c), {7'b0, d1_gnt1, d1_gnt0},
                (c % 3 != 0) ? 9'd0 : (((c / 3) % 2 == 0) ? 9'd1 : 9'd2));
        end

        // LAT=3 with back-pressure and a pending req1
        do_reset();
        rsp_rdy = 0;
        req0 = 1; a0 = 8'h10; b0 = 8'h20;
        tick();
        chk("l3 gnt0", {7'b0, d3_gnt1, d3_gnt0}, 9'd1);
        req0 = 0; req1 = 1; a1 = 8'h05; b1 = 8'h06;
        tick();
        chk("l3 exec2", {7'b0, d3_vld, d3_busy}, 9'd1);
        tick();
        chk("l3 exec3", {7'b0, d3_vld, d3_busy}, 9'd1);
        tick();
        chk("l3 rsp", {d3_vld, d3_id, d3_car, d3_sum[5:0]}, {3'b100, 6'h30});
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("l3 hold%0d", c), {d3_vld, d3_id, d3_gnt1, d3_gnt0, d3_car, 4'b0}, 9'h100);
            chk($sformatf("l3 hold sum%0d", c), {1'b0, d3_sum}, 9'h030);
        end
        rsp_rdy = 1;
        tick();
        chk("l3 idle", {6'b0, d3_vld, d3_busy, d3_gnt1}, 9'd0);
        tick();
        chk("l3 gnt1", {7'b0, d3_gnt1, d3_gnt0}, 9'd2);
        req1 = 0;
        tick();
        tick();
        chk("l3 pre rsp1", {8'b0, d3_vld}, 9'd0);
        tick();
        chk("l3 rsp1", {d3_vld, d3_id, d3_car, 6'b0}, 9'h180);
        chk("l3 rsp1 sum", {1'b0, d3_sum}, 9'h00B);

        // Reset pulsed during EXEC aborts the operation
        do_reset();
        req0 = 1; a0 = 8'h33; b0 = 8'h44;
        tick();
        chk("abort gnt", {8'b0, d3_gnt0}, 9'd1);
        req0 = 0;
        rst_n = 0;
        #1;
        zeros3("abort");
        zeros1("abort");
        #3;
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("abort quiet%0d", c), {7'b0, d3_vld, d3_busy}, 9'd0);
        end
        req1 = 1; a1 = 8'h01; b1 = 8'h02;
        tick();
        chk("abort new gnt", {7'b0, d3_gnt1, d3_gnt0}, 9'd2);
        req1 = 0;
        tick();
        tick();
        tick();
        chk("abort new rsp", {d3_vld, d3_id, d3_sum[6:0]}, {2'b11, 7'h03});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
